// File: rtl/tlu_emulator_pkg.sv
// Shared constants for the TLU emulator: FSM state encoding and synchronizer depth.
package tlu_emulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_TRIG  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_RST   = 2'd3;

  localparam int SYNC_STAGES = 3;

endpackage

// File: rtl/tlu_emulator_if.sv
// TLU trigger/busy/clock/reset handshake lines; master is the TLU side, slave the controller side.
interface tlu_emulator_if;

  logic TLU_CLOCK;
  logic TLU_BUSY;
  logic TLU_TRIGGER;
  logic TLU_RESET;

  modport master (
    input  TLU_CLOCK,
    input  TLU_BUSY,
    output TLU_TRIGGER,
    output TLU_RESET
  );

  modport slave (
    output TLU_CLOCK,
    output TLU_BUSY,
    input  TLU_TRIGGER,
    input  TLU_RESET
  );

endinterface

// File: rtl/three_stage_synchronizer.sv
// Flop chain bringing an asynchronous level into the SYS_CLK domain.
module three_stage_synchronizer
  import tlu_emulator_pkg::*;
(
  input  logic SYS_CLK,
  input  logic SYS_RST,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) stages <= '0;
    else         stages <= {stages[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/tlu_emulator_trig_gen.sv
// Trigger request source: periodic tick generator, external request merge and veto counting.
module tlu_emulator_trig_gen (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        ENABLE,
  input  logic        TRIG_REQ,
  input  logic [15:0] PERIOD,
  input  logic        can_accept,
  output logic        req_accept,
  output logic [15:0] VETO_COUNT
);

  logic [15:0] period_cnt;
  logic        tick;
  logic        req;

  // >= rather than == so a PERIOD lowered below the running count still wraps promptly
  always_comb begin
    tick       = ENABLE && (PERIOD != 16'd0) && (period_cnt >= PERIOD - 16'd1);
    req        = ENABLE && (TRIG_REQ || tick);
    req_accept = req && can_accept;
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      period_cnt <= '0;
      VETO_COUNT <= '0;
    end else begin
      if (!ENABLE || (PERIOD == 16'd0) || tick) period_cnt <= '0;
      else                                      period_cnt <= period_cnt + 16'd1;
      if (req && !can_accept && (VETO_COUNT != 16'hFFFF))
        VETO_COUNT <= VETO_COUNT + 16'd1;
    end
  end

endmodule

// File: rtl/tlu_emulator.sv
// TLU emulator top: trigger FSM, serial ID shift register and counters facing a tlu_controller.
module tlu_emulator
  import tlu_emulator_pkg::*;
#(
  parameter int TRIG_ID_WIDTH = 15,
  parameter int RESET_LEN     = 4
) (
  input  logic                     SYS_CLK,
  input  logic                     SYS_RST,
  input  logic                     ENABLE,
  input  logic                     TRIG_REQ,
  input  logic [15:0]              PERIOD,
  input  logic [15:0]              TIMEOUT,
  input  logic                     RESET_REQ,
  tlu_emulator_if.master           tlu,
  output logic [TRIG_ID_WIDTH-1:0] TRIG_ID,
  output logic [31:0]              TRIG_COUNT,
  output logic [15:0]              VETO_COUNT,
  output logic                     TIMEOUT_FLAG,
  output logic                     READY
);

  logic                   busy_s, clk_s, clk_s_d, clk_rise;
  state_t                 state, state_nxt;
  logic [TRIG_ID_WIDTH:0] sr, sr_nxt;
  logic [15:0]            wait_cnt, rst_cnt;
  logic                   rst_pend, rst_pend_nxt, rst_enter;
  logic                   can_accept, req_accept, timeout_hit;

  three_stage_synchronizer u_sync_busy (
    .SYS_CLK (SYS_CLK), .SYS_RST (SYS_RST), .async_in (tlu.TLU_BUSY),  .sync_out (busy_s)
  );

  three_stage_synchronizer u_sync_clk (
    .SYS_CLK (SYS_CLK), .SYS_RST (SYS_RST), .async_in (tlu.TLU_CLOCK), .sync_out (clk_s)
  );

  tlu_emulator_trig_gen u_trig_gen (
    .SYS_CLK    (SYS_CLK),
    .SYS_RST    (SYS_RST),
    .ENABLE     (ENABLE),
    .TRIG_REQ   (TRIG_REQ),
    .PERIOD     (PERIOD),
    .can_accept (can_accept),
    .req_accept (req_accept),
    .VETO_COUNT (VETO_COUNT)
  );

  // A pending reset outranks a trigger, so it also blocks acceptance
  assign can_accept   = (state == ST_IDLE) && !rst_pend && !(busy_s || clk_s);
  assign clk_rise     = clk_s && !clk_s_d;
  assign rst_enter    = (state == ST_IDLE) && rst_pend;
  assign rst_pend_nxt = RESET_REQ || (rst_pend && !rst_enter);

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_pend) state_nxt = ST_RST;
        else if (req_accept) begin
          state_nxt = ST_TRIG;
          sr_nxt    = {TRIG_ID, 1'b0};
        end
      end
      ST_TRIG: begin
        if (busy_s) state_nxt = ST_SHIFT;
        else if ((TIMEOUT != 16'd0) && (({1'b0, wait_cnt} + 17'd1) == {1'b0, TIMEOUT})) begin
          state_nxt   = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (clk_rise) sr_nxt = {1'b0, sr[TRIG_ID_WIDTH:1]};
        if (!busy_s)  state_nxt = ST_IDLE;
      end
      ST_RST: begin
        if (rst_cnt == 16'(RESET_LEN - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line outputs are registered from next-state values so they move with the FSM
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state           <= ST_IDLE;
      sr              <= '0;
      clk_s_d         <= 1'b0;
      rst_pend        <= 1'b0;
      wait_cnt        <= '0;
      rst_cnt         <= '0;
      TRIG_ID         <= '0;
      TRIG_COUNT      <= '0;
      TIMEOUT_FLAG    <= 1'b0;
      READY           <= 1'b0;
      tlu.TLU_TRIGGER <= 1'b0;
      tlu.TLU_RESET   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      clk_s_d  <= clk_s;
      rst_pend <= rst_pend_nxt;
      wait_cnt <= (state == ST_TRIG) ? wait_cnt + 16'd1 : 16'd0;
      rst_cnt  <= (state == ST_RST)  ? rst_cnt + 16'd1  : 16'd0;
      if (rst_enter) TRIG_ID <= '0;
      else if (req_accept) TRIG_ID <= TRIG_ID + 1'b1;
      if (req_accept) TRIG_COUNT <= TRIG_COUNT + 32'd1;
      TIMEOUT_FLAG    <= timeout_hit;
      READY           <= (state_nxt == ST_IDLE) && !rst_pend_nxt && !(busy_s || clk_s);
      tlu.TLU_TRIGGER <= (state_nxt == ST_TRIG) || ((state_nxt == ST_SHIFT) && sr_nxt[0]);
      tlu.TLU_RESET   <= (state_nxt == ST_RST);
    end
  end

endmodule

// File: tb/tb_tlu_emulator.sv
// Bench for tlu_emulator: plays the controller side of the handshake and checks against a trigger/ID model.
module tb_tlu_emulator;

  localparam int W  = 5;
  localparam int RL = 4;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST, ENABLE, TRIG_REQ, RESET_REQ;
  logic [15:0]   PERIOD, TIMEOUT;
  logic [W-1:0]  TRIG_ID;
  logic [31:0]   TRIG_COUNT;
  logic [15:0]   VETO_COUNT;
  logic          TIMEOUT_FLAG, READY;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_id;
  int            exp_trig, exp_veto;
  bit            gen_on;
  logic [W-1:0]  id_q[$];

  tlu_emulator_if tlu ();

  tlu_emulator #(.TRIG_ID_WIDTH(W), .RESET_LEN(RL)) dut (
    .SYS_CLK      (SYS_CLK),
    .SYS_RST      (SYS_RST),
    .ENABLE       (ENABLE),
    .TRIG_REQ     (TRIG_REQ),
    .PERIOD       (PERIOD),
    .TIMEOUT      (TIMEOUT),
    .RESET_REQ    (RESET_REQ),
    .tlu          (tlu),
    .TRIG_ID      (TRIG_ID),
    .TRIG_COUNT   (TRIG_COUNT),
    .VETO_COUNT   (VETO_COUNT),
    .TIMEOUT_FLAG (TIMEOUT_FLAG),
    .READY        (READY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_trig();
    TRIG_REQ = 1'b1;
    @(negedge SYS_CLK);
    TRIG_REQ = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (READY !== 1'b1 && n < 50) begin @(negedge SYS_CLK); n++; end
    checks++;
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL wait_ready: got %b expected 1", READY); end
  endtask

  // Controller side: answer a raised trigger with busy, clock out the ID, then drop busy
  task automatic run_handshake(input int edges, input int hold, input bit do_reset,
                               output logic [W-1:0] id, output int rst_cycles, output bit early_rst);
    int n;
    id = '0; rst_cycles = 0; early_rst = 1'b0;
    n = 0;
    while (tlu.TLU_TRIGGER !== 1'b1 && n < 20) begin @(negedge SYS_CLK); n++; end
    checks++;
    if (tlu.TLU_TRIGGER !== 1'b1) begin errors++; $display("[TB] FAIL trigger_seen: got %b expected 1", tlu.TLU_TRIGGER); end
    tlu.TLU_BUSY = 1'b1;
    n = 0;
    while (tlu.TLU_TRIGGER !== 1'b0 && n < 20) begin @(negedge SYS_CLK); n++; end
    checks++;
    if (tlu.TLU_TRIGGER !== 1'b0) begin errors++; $display("[TB] FAIL trigger_drop_on_busy: got %b expected 0", tlu.TLU_TRIGGER); end
    repeat (hold) @(negedge SYS_CLK);
    for (int k = 1; k <= edges; k++) begin
      tlu.TLU_CLOCK = 1'b1;
      repeat (4) @(negedge SYS_CLK);
      tlu.TLU_CLOCK = 1'b0;
      repeat (3) @(negedge SYS_CLK);
      if (k <= W) id[k-1] = tlu.TLU_TRIGGER;
      else begin
        checks++;
        if (tlu.TLU_TRIGGER !== 1'b0) begin errors++; $display("[TB] FAIL extra_edge_bit: got %b expected 0", tlu.TLU_TRIGGER); end
      end
      if (tlu.TLU_RESET !== 1'b0) early_rst = 1'b1;
      if (do_reset && k == 2) begin
        RESET_REQ = 1'b1;
        @(negedge SYS_CLK);
        RESET_REQ = 1'b0;
      end else @(negedge SYS_CLK);
      if (tlu.TLU_RESET !== 1'b0) early_rst = 1'b1;
    end
    tlu.TLU_BUSY = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 40) begin
      @(negedge SYS_CLK);
      n++;
      if (tlu.TLU_RESET === 1'b1) rst_cycles++;
    end
    checks++;
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_handshake: got %b expected 1", READY); end
  endtask

  task automatic check_totals(input string name);
    checks++;
    if (TRIG_COUNT !== 32'(exp_trig)) begin errors++; $display("[TB] FAIL %s_trig_count: got %0d expected %0d", name, TRIG_COUNT, exp_trig); end
    checks++;
    if (VETO_COUNT !== 16'(exp_veto)) begin errors++; $display("[TB] FAIL %s_veto_count: got %0d expected %0d", name, VETO_COUNT, exp_veto); end
  endtask

  task automatic test_reset();
    SYS_RST = 1'b1; ENABLE = 1'b1; TRIG_REQ = 1'b0; RESET_REQ = 1'b0;
    PERIOD = 16'd0; TIMEOUT = 16'd0;
    tlu.TLU_CLOCK = 1'b0; tlu.TLU_BUSY = 1'b0;
    exp_id = '0; exp_trig = 0; exp_veto = 0;
    repeat (4) @(negedge SYS_CLK);
    checks++;
    if ({tlu.TLU_TRIGGER, tlu.TLU_RESET, TIMEOUT_FLAG, READY} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {tlu.TLU_TRIGGER, tlu.TLU_RESET, TIMEOUT_FLAG, READY});
    end
    checks++;
    if (TRIG_ID !== '0) begin errors++; $display("[TB] FAIL reset_trig_id: got %0d expected 0", TRIG_ID); end
    check_totals("reset");
    SYS_RST = 1'b0;
    @(negedge SYS_CLK);
    checks++;
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: got %b expected 1", READY); end
  endtask

  task automatic test_single_trigger();
    logic [W-1:0] id, nxt;
    int rc;
    bit er;
    for (int i = 0; i < 3; i++) begin
      pulse_trig();
      nxt = exp_id + 1'b1;
      checks++;
      if (TRIG_ID !== nxt) begin errors++; $display("[TB] FAIL single_next_id: got %0d expected %0d", TRIG_ID, nxt); end
      run_handshake(W, 2, 1'b0, id, rc, er);
      checks++;
      if (id !== exp_id) begin errors++; $display("[TB] FAIL single_id: got %0d expected %0d", id, exp_id); end
      exp_id = nxt;
      exp_trig++;
    end
    check_totals("single");
  endtask

  task automatic test_timeout();
    int high, flags;
    logic [W-1:0] id;
    int rc;
    bit er;
    TIMEOUT = 16'd50;
    pulse_trig();
    exp_id = exp_id + 1'b1;
    exp_trig++;
    high = 0; flags = 0;
    for (int n = 0; n < 120; n++) begin
      if (tlu.TLU_TRIGGER === 1'b1) high++;
      if (TIMEOUT_FLAG === 1'b1) flags++;
      @(negedge SYS_CLK);
    end
    checks++;
    if (high != 50) begin errors++; $display("[TB] FAIL timeout_trigger_len: got %0d expected 50", high); end
    checks++;
    if (flags != 1) begin errors++; $display("[TB] FAIL timeout_flag_pulses: got %0d expected 1", flags); end
    TIMEOUT = 16'd0;
    wait_ready();
    pulse_trig();
    run_handshake(W, 1, 1'b0, id, rc, er);
    checks++;
    if (id !== exp_id) begin errors++; $display("[TB] FAIL after_timeout_id: got %0d expected %0d", id, exp_id); end
    exp_id = exp_id + 1'b1;
    exp_trig++;
  endtask

  task automatic test_deferred_reset();
    logic [W-1:0] id;
    int rc;
    bit er;
    pulse_trig();
    run_handshake(W, 2, 1'b1, id, rc, er);
    exp_trig++;
    checks++;
    if (id !== exp_id) begin errors++; $display("[TB] FAIL deferred_id: got %0d expected %0d", id, exp_id); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("[TB] FAIL reset_during_shift: got %b expected 0", er); end
    checks++;
    if (rc != RL) begin errors++; $display("[TB] FAIL reset_pulse_len: got %0d expected %0d", rc, RL); end
    checks++;
    if (TRIG_ID !== '0) begin errors++; $display("[TB] FAIL id_after_reset: got %0d expected 0", TRIG_ID); end
    exp_id = '0;
    pulse_trig();
    run_handshake(W, 0, 1'b0, id, rc, er);
    checks++;
    if (id !== '0) begin errors++; $display("[TB] FAIL first_id_after_reset: got %0d expected 0", id); end
    exp_id = exp_id + 1'b1;
    exp_trig++;
  endtask

  // Ticks that find the emulator busy must show up as vetoes, the rest as consecutive IDs
  task automatic test_periodic();
    int p, cycles, ticks, got;
    logic [W-1:0] id, want;
    int rc;
    bit er;
    p = $urandom_range(15, 30);
    cycles = 1000;
    ticks = cycles / p;
    id_q.delete();
    gen_on = 1'b1;
    fork
      begin
        PERIOD = 16'(p);
        repeat (cycles) @(negedge SYS_CLK);
        PERIOD = 16'd0;
        repeat (3) @(negedge SYS_CLK);
        gen_on = 1'b0;
      end
      begin
        while (gen_on) begin
          @(negedge SYS_CLK);
          if (tlu.TLU_TRIGGER === 1'b1) begin
            run_handshake(W, $urandom_range(0, 80), 1'b0, id, rc, er);
            id_q.push_back(id);
          end
        end
      end
    join
    got = id_q.size();
    checks++;
    if (got < 2 || got >= ticks) begin errors++; $display("[TB] FAIL periodic_trigger_share: got %0d expected 2..%0d", got, ticks - 1); end
    want = exp_id;
    foreach (id_q[i]) begin
      checks++;
      if (id_q[i] !== want) begin errors++; $display("[TB] FAIL periodic_id: got %0d expected %0d", id_q[i], want); end
      want = want + 1'b1;
    end
    exp_id = want;
    exp_trig += got;
    exp_veto += ticks - got;
    check_totals("periodic");
  endtask

  task automatic test_id_wrap();
    int n;
    logic [W-1:0] id, nxt;
    int rc;
    bit er;
    n = (2 ** W) - int'(exp_id) + 1;
    for (int i = 0; i < n; i++) begin
      pulse_trig();
      nxt = exp_id + 1'b1;
      checks++;
      if (TRIG_ID !== nxt) begin errors++; $display("[TB] FAIL wrap_next_id: got %0d expected %0d", TRIG_ID, nxt); end
      if ($urandom_range(0, 1) == 1) begin
        pulse_trig();
        exp_veto++;
      end
      run_handshake(W + $urandom_range(0, 2), $urandom_range(0, 5), 1'b0, id, rc, er);
      checks++;
      if (id !== exp_id) begin errors++; $display("[TB] FAIL wrap_id: got %0d expected %0d", id, exp_id); end
      exp_id = nxt;
      exp_trig++;
    end
    check_totals("wrap");
  endtask

  task automatic test_reset_mid_handshake();
    pulse_trig();
    tlu.TLU_BUSY = 1'b1;
    repeat (8) @(negedge SYS_CLK);
    tlu.TLU_CLOCK = 1'b1;
    repeat (4) @(negedge SYS_CLK);
    tlu.TLU_CLOCK = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    tlu.TLU_BUSY = 1'b0;
    @(negedge SYS_CLK);
    exp_id = '0; exp_trig = 0; exp_veto = 0;
    checks++;
    if ({tlu.TLU_TRIGGER, tlu.TLU_RESET, READY} !== 3'b000) begin
      errors++; $display("[TB] FAIL midreset_lines: got %b expected 000", {tlu.TLU_TRIGGER, tlu.TLU_RESET, READY});
    end
    checks++;
    if (TRIG_ID !== '0) begin errors++; $display("[TB] FAIL midreset_trig_id: got %0d expected 0", TRIG_ID); end
    check_totals("midreset");
    SYS_RST = 1'b0;
    @(negedge SYS_CLK);
    checks++;
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", READY); end
  endtask

  initial begin
    test_reset();
    test_single_trigger();
    test_timeout();
    test_deferred_reset();
    test_periodic();
    test_id_wrap();
    test_reset_mid_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
